// File: rtl/cram_axi_read_slave.sv
// cram_axi_read_slave: AXI4 read-only responder for the code RAM, plus a loader write port.
// Latency: AR accepted at edge k -> first R beat valid after edge k+2, then 1 beat/cycle.
// Backpressure: 2-entry skid buffer behind the 1-cycle RAM; a read issues only if its slot is free.
// Ports: clk, rst (async, active-high); s_ar* read-address channel; s_r* read-data channel;
//        ld_en/ld_addr/ld_data loader word write, independent of the AXI side.
module cram_axi_read_slave #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 13,
  parameter int ID_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       s_arid,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_W-1:0]       s_rid,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data
);

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t state, state_nxt;

  // Keeps arready low until the first clock edge after reset is released.
  logic armed;

  // Latched burst descriptor
  logic [ID_W-1:0]       id_q;
  logic [DEPTH_LOG2-1:0] base_q;
  logic [7:0]            len_q;
  logic                  fixed_q;
  logic                  err_q;

  // Read issue side
  logic [8:0]            rd_cnt;    // reads issued so far in this burst (0..len+1)
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [2:0]            occ;       // buffer entries committed after this edge

  // RAM and its registered read port
  logic [DATA_W-1:0]     mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_W-1:0]     ram_q;
  logic                  ram_vld;
  logic                  ram_last;

  // Two-entry skid buffer feeding the R channel
  logic [DATA_W-1:0]     buf_data [2];
  logic [1:0]            buf_resp [2];
  logic                  buf_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic                  ar_hs;
  logic                  pop;
  logic                  addr_oor;
  logic                  unused_addr_bits;

  assign ar_hs    = s_arvalid && s_arready;
  assign s_rvalid = (count != 2'd0);
  assign pop      = s_rvalid && s_rready;
  assign addr_oor = |s_araddr[ADDR_W-1:DEPTH_LOG2+2];
  assign unused_addr_bits = ^s_araddr[1:0];

  assign s_rid   = id_q;
  assign s_rdata = buf_data[rd_ptr];
  assign s_rresp = buf_resp[rd_ptr];
  assign s_rlast = buf_last[rd_ptr];

  // INCR wraps naturally at the RAM depth because the sum is DEPTH_LOG2 bits wide.
  assign rd_addr = fixed_q ? base_q : base_q + DEPTH_LOG2'(rd_cnt);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ar_hs) state_nxt = BURST;
      BURST:   if (pop && s_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A read is allowed only if buffer + in-flight RAM word, after this cycle's pop,
  // leaves room for it; the RAM output is then always pushed unconditionally.
  always_comb begin
    s_arready = 1'b0;
    rd_en     = 1'b0;
    occ       = {1'b0, count} + {2'b00, ram_vld} - {2'b00, pop};
    case (state)
      IDLE:    s_arready = armed;
      BURST:   rd_en = (rd_cnt <= {1'b0, len_q}) && (occ < 3'd2);
      default: ;
    endcase
  end

  // ---------------- Burst descriptor and issue counter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q     <= '0;
      base_q   <= '0;
      len_q    <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt   <= '0;
      ram_vld  <= 1'b0;
      ram_last <= 1'b0;
    end else begin
      if (ar_hs) begin
        id_q    <= s_arid;
        base_q  <= s_araddr[DEPTH_LOG2+1:2];
        len_q   <= s_arlen;
        fixed_q <= (s_arburst == 2'd0);
        err_q   <= (s_arsize != 3'd2) || s_arburst[1] || addr_oor;
        rd_cnt  <= '0;
      end else if (rd_en) begin
        rd_cnt  <= rd_cnt + 9'd1;
      end
      ram_vld  <= rd_en;
      ram_last <= rd_en && (rd_cnt == {1'b0, len_q});
    end
  end

  // ---------------- RAM (not reset) ----------------
  // Read-before-write: a same-edge read of the word being loaded sees the old value.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  // ---------------- Skid buffer ----------------
  // Error bursts still walk the pipeline so beat count and rlast timing are unchanged;
  // only the payload is replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_resp[i] <= 2'd0;
        buf_last[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (ram_vld) begin
        buf_data[wr_ptr] <= err_q ? '0 : ram_q;
        buf_resp[wr_ptr] <= err_q ? 2'd2 : 2'd0;
        buf_last[wr_ptr] <= ram_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, ram_vld} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_cram_axi_read_slave.sv
// tb_cram_axi_read_slave: directed bench for the cram AXI read slave.
// Expected R beats come from a bench-side RAM image and burst address arithmetic;
// one negedge process compares every valid beat and arready against that model.
module tb_cram_axi_read_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid;
  logic        s_arready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready;
  logic        ld_en;
  logic [12:0] ld_addr;
  logic [31:0] ld_data;

  cram_axi_read_slave dut (
    .clk       (clk),
    .rst       (rst),
    .s_arid    (s_arid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rid     (s_rid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          hs_cyc      = 0;
  int          since_rst   = 0;
  bit          outstanding = 1'b0;
  bit          first_pending = 1'b0;
  bit          rr_mode     = 1'b0;
  int          rr_idx      = 0;
  logic        rr_pat [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] model_ram [8192];
  beat_t       exp_q [$];
  logic [31:0] log_data [$];
  logic [1:0]  log_resp [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic [31:0] d = 32'hDEADDEAD;
    logic [1:0]  r = 2'b11;
    if (idx < log_data.size()) begin
      d = log_data[idx];
      r = log_resp[idx];
    end
    check({name, "_data"}, {32'h0, d}, {32'h0, exp_d});
    check({name, "_resp"}, {62'h0, r}, {62'h0, exp_r});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) since_rst <= 0;
    else if (since_rst < 3) since_rst <= since_rst + 1;
  end

  // rready driver: always high, or a fixed stall pattern
  initial begin
    s_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode) begin
        s_rready = rr_pat[rr_idx];
        rr_idx   = (rr_idx + 1) % 12;
      end else begin
        s_rready = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("arready", {63'h0, s_arready}, {63'h0, (since_rst >= 1) && !outstanding});
      if (s_rvalid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got rvalid=1 data=%0h expected no beat", s_rdata);
        end else begin
          if (first_pending) begin
            check("first_beat_latency", 64'(cyc - hs_cyc), 64'd2);
            first_pending = 1'b0;
          end
          check("rdata", {32'h0, s_rdata}, {32'h0, exp_q[0].data});
          check("rresp", {62'h0, s_rresp}, {62'h0, exp_q[0].resp});
          check("rlast", {63'h0, s_rlast}, {63'h0, exp_q[0].last});
          check("rid",   {60'h0, s_rid},   {60'h0, exp_q[0].id});
          if (s_rready) begin
            log_data.push_back(s_rdata);
            log_resp.push_back(s_rresp);
            if (exp_q[0].last) outstanding = 1'b0;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic load(input logic [12:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    model_ram[a] = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  // Expected beats from the burst rules: word index from byte address, INCR wraps at 8192 words.
  task automatic model_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit    err;
    int    w;
    int    word;
    beat_t b;
    err = (size != 3'd2) || (burst >= 2'd2) || ((addr >> 15) != 0);
    w   = int'((addr >> 2) & 32'h1FFF);
    for (int i = 0; i <= int'(len); i++) begin
      word   = (burst == 2'd0) ? w : (w + i) % 8192;
      b.id   = id;
      b.data = err ? 32'h0 : model_ram[word];
      b.resp = err ? 2'd2 : 2'd0;
      b.last = (i == int'(len));
      exp_q.push_back(b);
    end
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    s_arid    = id;
    s_araddr  = addr;
    s_arlen   = len;
    s_arsize  = size;
    s_arburst = burst;
    s_arvalid = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (s_arready) break;
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL ar_timeout: got arready=0 for 50 cycles expected 1");
      @(posedge clk);
      #1;
      s_arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_arvalid     = 1'b0;
    hs_cyc        = cyc;
    model_burst(id, addr, len, size, burst);
    outstanding   = 1'b1;
    first_pending = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (outstanding && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (outstanding) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got burst still open expected done", name);
      outstanding = 1'b0;
      exp_q.delete();
    end
    @(negedge clk);
    check({name, "_arready_after_last"}, {63'h0, s_arready}, 64'd1);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1 [4];
    int n;
    t1 = '{32'h10, 32'h11, 32'h12, 32'h13};
    for (int i = 0; i < 8192; i++) model_ram[i] = 32'h0;
    rst = 1'b1;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state
    #1;
    check("rst_arready", {63'h0, s_arready}, 64'd0);
    check("rst_rvalid",  {63'h0, s_rvalid},  64'd0);
    check("rst_rlast",   {63'h0, s_rlast},   64'd0);
    check("rst_rresp",   {62'h0, s_rresp},   64'd0);
    check("rst_rid",     {60'h0, s_rid},     64'd0);
    check("rst_rdata",   {32'h0, s_rdata},   64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("arready_before_first_clk", {63'h0, s_arready}, 64'd0);
    @(posedge clk);
    #1;
    check("arready_after_first_clk", {63'h0, s_arready}, 64'd1);

    for (int i = 0; i < 4; i++) load(13'(i), t1[i]);
    load(13'h1FFF, 32'hCAFE1FFF);

    // 1: INCR len=3, rready high
    rr_mode = 1'b0;
    log_data.delete(); log_resp.delete();
    do_ar(4'd5, 32'h0, 8'd3, 3'd2, 2'd1);
    wait_done("t1");
    check("t1_count", 64'(log_data.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_log("t1_beat", i, t1[i], 2'd0);

    // 2: same burst with rready stalls
    rr_mode = 1'b1;
    log_data.delete(); log_resp.delete();
    do_ar(4'd5, 32'h0, 8'd3, 3'd2, 2'd1);
    wait_done("t2");
    rr_mode = 1'b0;
    check("t2_count", 64'(log_data.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_log("t2_beat", i, t1[i], 2'd0);

    // 3: back-to-back single beats at +4 steps
    log_data.delete(); log_resp.delete();
    do_ar(4'd2, 32'h4, 8'd0, 3'd2, 2'd1);
    wait_done("t3a");
    do_ar(4'd3, 32'h8, 8'd0, 3'd2, 2'd1);
    wait_done("t3b");
    check_log("t3_first", 0, 32'h11, 2'd0);
    check_log("t3_second", 1, 32'h12, 2'd0);

    // 4: illegal size, then out-of-range address
    log_data.delete(); log_resp.delete();
    do_ar(4'd7, 32'h0, 8'd1, 3'd1, 2'd1);
    wait_done("t4a");
    do_ar(4'd1, 32'h8000, 8'd0, 3'd2, 2'd1);
    wait_done("t4b");
    check("t4_count", 64'(log_data.size()), 64'd3);
    for (int i = 0; i < 3; i++) check_log("t4_err", i, 32'h0, 2'd2);

    // 4c: WRAP is rejected too
    log_data.delete(); log_resp.delete();
    do_ar(4'd6, 32'h0, 8'd1, 3'd2, 2'd2);
    wait_done("t4c");
    check_log("t4c_wrap", 1, 32'h0, 2'd2);

    // 5: FIXED burst, and INCR wrap past the last word
    log_data.delete(); log_resp.delete();
    do_ar(4'd4, 32'h8, 8'd2, 3'd2, 2'd0);
    wait_done("t5a");
    do_ar(4'd9, 32'h7FFC, 8'd1, 3'd2, 2'd1);
    wait_done("t5b");
    for (int i = 0; i < 3; i++) check_log("t5_fixed", i, 32'h12, 2'd0);
    check_log("t5_wrap_hi", 3, 32'hCAFE1FFF, 2'd0);
    check_log("t5_wrap_lo", 4, 32'h10, 2'd0);

    // 6: reset during beat 2 of a len=7 burst
    log_data.delete(); log_resp.delete();
    do_ar(4'd8, 32'h0, 8'd7, 3'd2, 2'd1);
    n = 0;
    while (log_data.size() < 1 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("t6_first_beat_seen", 64'(log_data.size()), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    outstanding   = 1'b0;
    first_pending = 1'b0;
    #1;
    check("t6_rvalid_in_rst",  {63'h0, s_rvalid},  64'd0);
    check("t6_arready_in_rst", {63'h0, s_arready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_arready_pre_clk", {63'h0, s_arready}, 64'd0);
    @(negedge clk);
    check("t6_arready_post_clk", {63'h0, s_arready}, 64'd1);
    check("t6_rvalid_post", {63'h0, s_rvalid}, 64'd0);
    @(posedge clk);
    #1;
    log_data.delete(); log_resp.delete();
    do_ar(4'd5, 32'h0, 8'd0, 3'd2, 2'd1);
    wait_done("t6");
    check_log("t6_ram_kept", 0, 32'h10, 2'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cram_axi_read_slave.md
Name: cram_axi_read_slave

Overview:
- AXI4 read-only responder for the code RAM (cram) that serves instruction fetches from the scheduler's s_cram_* master port.
- Accepts one AR burst at a time, reads the internal word-organised RAM, and returns R beats with rid echoed and rlast on the final beat.
- Provides a simple side write port used by the loader to fill program memory before or between runs.

Parameters:
- ADDR_W, 32, AXI address width; byte address.
- DATA_W, 32, data width; must be 32.
- DEPTH_LOG2, 13, log2 of RAM depth in 32-bit words. Covers the 15-bit CRAM_ADDR_W byte space.
- ID_W, 4, AXI ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_arid  in  ID_W  read ID.
- s_araddr  in  ADDR_W  byte address of the first beat.
- s_arlen  in  8  beats minus 1.
- s_arsize  in  3  beat size; only 2 is legal.
- s_arburst  in  2  0 = FIXED, 1 = INCR, 2 = WRAP.
- s_arvalid  in  1  AR valid.
- s_arready  out  1  AR ready.
- s_rid  out  ID_W  echoed ID.
- s_rdata  out  DATA_W  read data.
- s_rresp  out  2  0 = OKAY, 2 = SLVERR.
- s_rlast  out  1  last beat of the burst.
- s_rvalid  out  1  R valid.
- s_rready  in  1  R ready.
- ld_en  in  1  loader write strobe.
- ld_addr  in  DEPTH_LOG2  loader word address.
- ld_data  in  DATA_W  loader write data.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; s_arready = 0 while rst is high, 1 from the first clk after rst falls. Also cleared: s_rvalid, s_rlast, s_rresp, s_rid, s_rdata, beat counter and output buffer. RAM contents are not cleared. Reset mid-burst drops s_rvalid immediately and discards the remaining beats.
- FSM states:
  - IDLE: s_arready = 1. On s_arvalid && s_arready, latch id, word index = s_araddr[DEPTH_LOG2+1:2] (bits [1:0] ignored), len, error flag; go to BURST.
  - BURST: s_arready = 0. Issue RAM reads; return to IDLE on the edge where a beat with s_rlast is accepted (s_rvalid && s_rready && s_rlast). s_arready is 1 in the following cycle; only one burst is outstanding.
- Error flag: set if s_arsize != 2, s_arburst == 2 (WRAP), or s_arburst == 3.
- Latency: AR handshake at edge k gives the first s_rvalid = 1 after edge k+2.
- Throughput: 1 beat/cycle while s_rready stays high.
- Backpressure: RAM read latency is 1 cycle, so a 2-entry skid buffer holds in-flight data. The next RAM read is issued only if a buffer slot will be free. While s_rvalid && !s_rready, s_rdata, s_rresp, s_rlast and s_rid stay stable.
- Address per beat:
  - INCR: word index + beat number, 13-bit wrap-around at DEPTH (no 4 KB boundary check).
  - FIXED: same word for all beats.
- Beat fields:
  - Per beat: s_rresp = 2 and s_rdata = 0 if the error flag is set, else s_rresp = 0 and RAM data.
  - Out-of-range upper address bits (s_araddr[ADDR_W-1:DEPTH_LOG2+2] != 0): SLVERR with data 0 for all beats.
  - s_rlast = 1 exactly on beat arlen (0-based); s_rid = latched arid on every beat.
  - Error bursts still return arlen+1 beats.
- Loader:
  - ld_en writes ld_data to RAM[ld_addr] at the clk edge and is independent of the AXI side.
  - A same-cycle read and write to the same word returns the old data.
  - A write to a word not yet read in the current burst is visible to that later beat.

Test Plan:
- Load RAM[0..3] = 0x10,0x11,0x12,0x13; AR addr=0x0, len=3, size=2, INCR, id=5, rready=1 -> four consecutive beats 0x10..0x13, rid=5, rresp=0, rlast only on beat 4, first rvalid 2 cycles after the AR handshake, arready=1 on the cycle after the last beat.
- Same burst with rready toggling 1,0,0,1,0,1... -> no beat lost or duplicated, rdata stable while stalled, order 0x10..0x13.
- Back-to-back single-beat reads (len=0) at addr 0x4 then 0x8, matching the scheduler's +4 stepping -> data 0x11 then 0x12, rlast=1 on each beat, arready low between AR acceptance and R acceptance.
- AR with size=1, len=1 -> two beats, rresp=2, rdata=0, rlast on beat 2; then an AR with size=2 and INCR to addr 0x8000 -> 1 beat with SLVERR.
- FIXED burst at addr 0x8, len=2 -> three beats of 0x12; INCR burst at word 0x1FFF, len=1 -> RAM[0x1FFF] then RAM[0x0000].
- Assert rst during beat 2 of a len=7 burst -> s_rvalid=0 immediately; after release s_arready=1 next cycle; new AR to addr 0x0 returns 0x10; RAM contents retained.
